// File: rtl/prbs4_checker.sv
// prbs4_checker: self-synchronising checker for the x^4+x^3 LFSR word stream with flywheel error counting
module prbs4_checker #(
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_word,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);
    typedef enum logic {SEARCH, LOCKED} state_t;
    localparam logic [4:0] LT = 5'(LOCK_THRESH);
    localparam logic [4:0] UT = 5'(UNLOCK_THRESH);
    state_t state, state_n;
    logic [3:0] ref_w, ref_n, match_run, match_n, miss_run, miss_n, pred;
    logic [4:0] match_inc, miss_inc;
    logic have_prev, have_n, hit, acc, miss, err_n;
    logic [CNT_W-1:0] ec_n, wc_n;
    assign pred      = {ref_w[2:0], ref_w[3] ^ ref_w[2]};
    assign match_inc = {1'b0, match_run} + 5'd1;
    assign miss_inc  = {1'b0, miss_run} + 5'd1;
    assign hit       = have_prev && in_word == pred && in_word != 4'd0;
    assign acc       = in_valid && state == LOCKED;
    assign miss      = acc && in_word != pred;
    assign locked    = state == LOCKED;
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SEARCH;
            ref_w      <= '0;
            have_prev  <= 1'b0;
            match_run  <= '0;
            miss_run   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            ref_w      <= ref_n;
            have_prev  <= have_n;
            match_run  <= match_n;
            miss_run   <= miss_n;
            err_pulse  <= err_n;
            err_count  <= ec_n;
            word_count <= wc_n;
        end
    end
    always_comb begin
        state_n = state;
        ref_n   = ref_w;
        have_n  = have_prev;
        match_n = match_run;
        miss_n  = miss_run;
        if (in_valid && state == SEARCH) begin
            ref_n   = in_word;
            have_n  = 1'b1;
            match_n = hit ? match_inc[3:0] : 4'd0;
            if (hit && match_inc == LT) begin
                state_n = LOCKED;
                match_n = '0;
                miss_n  = '0;
            end
        end else if (acc) begin
            ref_n  = pred;
            miss_n = miss ? miss_inc[3:0] : 4'd0;
            // a run of misses means the flywheel lost phase: resync from the received word
            if (miss && miss_inc == UT) begin
                state_n = SEARCH;
                ref_n   = in_word;
                have_n  = 1'b1;
                match_n = '0;
                miss_n  = '0;
            end
        end
    end
    always_comb begin
        err_n = miss;
        ec_n  = clear ? '0 : (miss && err_count != '1) ? err_count + CNT_W'(1) : err_count;
        wc_n  = clear ? '0 : (acc && word_count != '1) ? word_count + CNT_W'(1) : word_count;
    end
endmodule

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: scoreboard bench with a table-driven reference model of the checker
module tb_prbs4_checker;
    localparam int LT = 4, UT = 3, CW = 4, SAT = 15;
    logic clock = 0, reset = 1, clear = 0, in_valid = 0;
    logic [3:0] in_word = 0;
    logic locked, err_pulse;
    logic [CW-1:0] err_count, word_count;
    int errors = 0, checks = 0;
    typedef struct {bit l; bit p; int e; int w;} exp_t;
    exp_t q[$];
    int seq[15] = '{13, 10, 5, 11, 7, 15, 14, 12, 8, 1, 2, 4, 9, 3, 6};
    bit m_lock, m_have;
    int m_ref, m_match, m_miss, m_ec, m_wc;

    prbs4_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_word(in_word),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
    );

    always #5 clock = ~clock;

    function automatic int succ(int w);
        for (int i = 0; i < 15; i++) if (seq[i] == w) return seq[(i + 1) % 15];
        return -1;
    endfunction

    task automatic model(bit r, bit c, bit v, int w);
        exp_t x;
        bit p = 0;
        int nx;
        if (r) begin
            m_lock = 0; m_have = 0; m_ref = 0; m_match = 0; m_miss = 0; m_ec = 0; m_wc = 0;
        end else begin
            if (v && !m_lock) begin
                bit hit = m_have && w != 0 && w == succ(m_ref);
                m_ref = w;
                m_have = 1;
                m_match = hit ? m_match + 1 : 0;
                if (m_match == LT) begin m_lock = 1; m_match = 0; m_miss = 0; end
            end else if (v) begin
                nx = succ(m_ref);
                m_ref = nx;
                m_wc = m_wc < SAT ? m_wc + 1 : SAT;
                if (w == nx) m_miss = 0;
                else begin
                    p = 1;
                    m_ec = m_ec < SAT ? m_ec + 1 : SAT;
                    m_miss++;
                    if (m_miss == UT) begin m_lock = 0; m_ref = w; m_have = 1; m_match = 0; m_miss = 0; end
                end
            end
            if (c) begin m_ec = 0; m_wc = 0; end
        end
        x.l = m_lock; x.p = p; x.e = m_ec; x.w = m_wc;
        q.push_back(x);
    endtask

    task automatic drive(bit r, bit c, bit v, int w);
        @(negedge clock);
        reset = r; clear = c; in_valid = v; in_word = 4'(w);
        model(r, c, v, w);
    endtask

    task automatic words(int n, int w0, int w1, int w2, int w3, int w4);
        int a[5] = '{w0, w1, w2, w3, w4};
        for (int i = 0; i < n; i++) drive(0, 0, 1, a[i]);
    endtask

    function automatic int next_good();
        int s = succ(m_ref);
        return (m_lock || (m_have && s > 0)) ? s : 13;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, b);
        end
    endtask

    initial forever begin
        exp_t x;
        @(posedge clock);
        #1;
        if (q.size() != 0) begin
            x = q.pop_front();
            chk("locked", 32'(locked), 32'(x.l));
            chk("err_pulse", 32'(err_pulse), 32'(x.p));
            chk("err_count", 32'(err_count), x.e);
            chk("word_count", 32'(word_count), x.w);
        end
    end

    initial begin
        repeat (2) drive(1, 0, 0, 0);
        words(5, 13, 10, 5, 11, 7);
        words(5, 15, 14, 0, 8, 1);
        words(3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        words(5, 13, 10, 5, 11, 7);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 80; i++) drive(0, 0, i % 2, 0);
        words(5, 13, 10, 5, 11, 7);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 1, next_good());
        end
        drive(0, 1, 1, 0);
        drive(0, 0, 1, next_good());
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 1, next_good());
        end
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        words(5, 13, 10, 5, 11, 7);
        for (int i = 0; i < 3000; i++) begin
            int w = $urandom_range(0, 9) < 8 ? next_good() : int'($urandom_range(0, 15));
            drive($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, w);
        end
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
